mult_issue_ctrl: RTL and testbench
==================================

Name: mult_issue_ctrl

Overview:
- Sequences the pipelined 16x16 multiplier execution unit between the multiply issue queue and the common data bus (CDB).
- Tracks each in-flight destination tag alongside the multiplier pipeline and drives the multiplier clock-enable.
- Holds one completed result in an output buffer until the CDB grants it.
- Backpressures the issue queue when a result cannot drain.

Parameters:
- LATENCY, 4, multiplier pipeline depth in enabled clock edges from operands to p.
- TAG_W, 6, destination (physical register) tag width.
- DATA_W, 32, multiplier product width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- issuemult_enable  in  1  issue queue presents a valid multiply this cycle
- issuemult_rdtag  in  TAG_W  destination tag of presented multiply
- issuemult_ready  out  1  controller accepts the presented multiply this cycle
- mult_ce  out  1  clock-enable to multiplier pipeline
- mult_p  in  DATA_W  multiplier product output
- cdb_req  out  1  request CDB slot for buffered result
- cdb_grant  in  1  CDB grant; ignored when cdb_req=0
- cdb_tag  out  TAG_W  tag of buffered result
- cdb_data  out  DATA_W  buffered product
- busy  out  1  any multiply in flight or buffered

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset), and clears all state immediately:
  - all stage valids = 0, stage tags = 0
  - out_valid = 0, cdb_tag = 0, cdb_data = 0
  - cdb_req = 0, busy = 0
  - mult_ce = 1 and issuemult_ready = 1, since the pipe is empty
- Tag pipe: vld[1..LATENCY] and tag[1..LATENCY] shift only on edges where mult_ce=1.
  - vld[1] <= accept; tag[1] <= issuemult_rdtag.
  - vld[i] <= vld[i-1] for i > 1.
  - vld[LATENCY]=1 means mult_p currently holds that entry's product.
- Advance rule (combinational): mult_ce = !vld[LATENCY] | !out_valid | cdb_grant.
- issuemult_ready = mult_ce. accept = issuemult_enable & mult_ce. Operand buses are routed directly to the multiplier; this block carries tags only.
- Output buffer, on an edge with mult_ce=1 and vld[LATENCY]=1:
  - out_valid <= 1, cdb_tag <= tag[LATENCY], cdb_data <= mult_p.
- Otherwise, if cdb_grant & out_valid: out_valid <= 0. cdb_tag and cdb_data hold their last values.
- Simultaneous grant and refill: the buffer reloads with the new result and out_valid stays 1. Throughput is one result per cycle.
- cdb_req = out_valid. It stays asserted, with tag and data stable, until granted.
- Latency: an accepted issue at edge t produces cdb_req=1 after edge t+LATENCY when never stalled.
- Stall: when vld[LATENCY]=1, out_valid=1 and cdb_grant=0, the whole pipe freezes (mult_ce=0) and no issue is accepted. Bubbles are not collapsed.
- Empty pipe with no issue: mult_ce stays 1 and zeros shift through harmlessly.
- busy = |vld | out_valid.
- Reset mid-operation discards all in-flight tags. The multiplier IP's own datapath contents are irrelevant because the valids are cleared.

Optional Feature:
- Macro MULT_FLUSH_EN.
- Defined: adds input issuemult_flush (1 bit).
  - When high at an edge, all vld bits and out_valid clear, regardless of mult_ce or grant.
  - Any issue presented that cycle is dropped (issuemult_ready forced 0).
  - cdb_req drops the following cycle.
- Undefined: the port is absent and no flush logic exists.

Decomposition:
- Shared header (`ifndef-guarded): TAG_W, DATA_W, MULT_LATENCY defaults, and the tag-valid bundle width macro, reused by the issue queue and CDB arbiter.
- One sub-module, mult_tag_pipe: parameterised LATENCY-deep valid+tag shift register with enable, asynchronous reset, and last-stage outputs.

Test Plan:
- Single issue, tag 6'h15, grant held 1: cdb_req rises exactly 4 cycles after accept with cdb_tag=15 and cdb_data = product (e.g. 3*7 = 21). busy drops the next cycle after grant.
- Back-to-back issues, tags 1..8, grant held 1: issuemult_ready stays 1 and results emerge on 8 consecutive cycles in order.
- Issue tags 1,2,3 back-to-back, grant=0 for 10 cycles: pipe freezes with tag 1 buffered and tag 2 at the last stage, mult_ce=0 and ready=0. Release grant: tags 1, 2, 3 emerge with correct products.
- Grant pulsed every other cycle with continuous issue: no tag lost or duplicated, and the scoreboard matches all products.
- Assert reset with 3 multiplies in flight and one buffered: cdb_req=0 and busy=0 immediately (asynchronously). The first issue after reset returns only its own tag.
- MULT_FLUSH_EN build: flush with 2 in flight plus 1 buffered, issue valid the same cycle: nothing appears on the CDB and ready=0 that cycle. The next issue completes normally.

Source files
------------

// File: rtl/mult_issue_ctrl_pkg.sv
// Shared multiply-unit definitions. The issue queue and CDB arbiter reuse them.
// Provides the default tag/data widths and the multiplier pipeline depth.
// Also provides `MULT_TAG_VLD_W(tag_w), the width of a {valid, tag} bundle.
`ifndef MULT_ISSUE_CTRL_PKG_SV
`define MULT_ISSUE_CTRL_PKG_SV

`define MULT_TAG_VLD_W(tag_w) ((tag_w) + 1)

package mult_issue_ctrl_pkg;
  localparam int MULT_TAG_W     = 6;
  localparam int MULT_DATA_W    = 32;
  localparam int MULT_LATENCY   = 4;
  localparam int MULT_TAG_VLD_W = `MULT_TAG_VLD_W(MULT_TAG_W);
endpackage

`endif

// File: rtl/mult_issue_ctrl_tag_pipe.sv
// mult_tag_pipe: a LATENCY-deep valid+tag shift register. It runs in lockstep with the multiplier.
// Latency: LATENCY enabled edges from in_vld/in_tag to last_vld/last_tag.
// Backpressure: the register holds (no shift) while en=0. Bubbles are kept, not collapsed.
// Ports:
//   clk, rst          clock and async active-high reset
//   clr               clears every stage valid (present only when MULT_FLUSH_EN is defined)
//   en                shift enable; matches the multiplier clock-enable
//   in_vld, in_tag    entry loaded into stage 1
//   last_vld/last_tag the final stage, aligned with the multiplier product
//   any_vld           OR of all stage valids
module mult_tag_pipe #(
  parameter int LATENCY = 4,
  parameter int TAG_W   = 6
) (
  input  logic             clk,
  input  logic             rst,
`ifdef MULT_FLUSH_EN
  input  logic             clr,
`endif
  input  logic             en,
  input  logic             in_vld,
  input  logic [TAG_W-1:0] in_tag,
  output logic             last_vld,
  output logic [TAG_W-1:0] last_tag,
  output logic             any_vld
);

  logic [LATENCY-1:0] stg_vld;
  logic [TAG_W-1:0]   stg_tag [LATENCY];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      for (int i = 0; i < LATENCY; i++) stg_tag[i] <= '0;
    end else begin
      if (en) begin
        stg_vld[0] <= in_vld;
        stg_tag[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
          stg_vld[i] <= stg_vld[i-1];
          stg_tag[i] <= stg_tag[i-1];
        end
      end
`ifdef MULT_FLUSH_EN
      // Flush overrides the shift: later non-blocking assignment wins.
      if (clr) stg_vld <= '0;
`endif
    end
  end

  assign last_vld = stg_vld[LATENCY-1];
  assign last_tag = stg_tag[LATENCY-1];
  assign any_vld  = |stg_vld;

endmodule

// File: rtl/mult_issue_ctrl.sv
// mult_issue_ctrl: sequences the pipelined multiplier between the issue queue and the CDB.
// Latency: an unstalled issue at edge t raises cdb_req after edge t+LATENCY. Throughput is one result per cycle.
// Backpressure: the pipe freezes and issue is refused when a result reaches the last stage while the buffer is full and not granted.
// Ports:
//   clk, reset                       clock and async active-high reset
//   issuemult_flush                  drop all in-flight/buffered work (only when MULT_FLUSH_EN is defined)
//   issuemult_enable/_rdtag/_ready   issue handshake; the operands go straight to the multiplier
//   mult_ce, mult_p                  multiplier clock-enable and product
//   cdb_req/_grant/_tag/_data        CDB request for the one-entry output buffer
//   busy                             any multiply in flight or buffered
module mult_issue_ctrl
  import mult_issue_ctrl_pkg::*;
#(
  parameter int LATENCY = MULT_LATENCY,
  parameter int TAG_W   = MULT_TAG_W,
  parameter int DATA_W  = MULT_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
`ifdef MULT_FLUSH_EN
  input  logic              issuemult_flush,
`endif
  input  logic              issuemult_enable,
  input  logic [TAG_W-1:0]  issuemult_rdtag,
  output logic              issuemult_ready,
  output logic              mult_ce,
  input  logic [DATA_W-1:0] mult_p,
  output logic              cdb_req,
  input  logic              cdb_grant,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic              busy
);

  logic             last_vld;
  logic [TAG_W-1:0] last_tag;
  logic             any_vld;
  logic             out_vld;
  logic             accept;

  // The pipe can advance when the last stage is empty, when the buffer is free,
  // or when the buffered result leaves this cycle.
  assign mult_ce = !last_vld | !out_vld | cdb_grant;

`ifdef MULT_FLUSH_EN
  assign issuemult_ready = mult_ce & !issuemult_flush;
`else
  assign issuemult_ready = mult_ce;
`endif

  assign accept = issuemult_enable & issuemult_ready;

  mult_tag_pipe #(
    .LATENCY (LATENCY),
    .TAG_W   (TAG_W)
  ) u_tag_pipe (
    .clk      (clk),
    .rst      (reset),
`ifdef MULT_FLUSH_EN
    .clr      (issuemult_flush),
`endif
    .en       (mult_ce),
    .in_vld   (accept),
    .in_tag   (issuemult_rdtag),
    .last_vld (last_vld),
    .last_tag (last_tag),
    .any_vld  (any_vld)
  );

  // One-entry output buffer. A refill in the same cycle as a grant keeps out_vld high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld  <= 1'b0;
      cdb_tag  <= '0;
      cdb_data <= '0;
    end else begin
      if (mult_ce && last_vld) begin
        out_vld  <= 1'b1;
        cdb_tag  <= last_tag;
        cdb_data <= mult_p;
      end else if (cdb_grant && out_vld) begin
        out_vld <= 1'b0;
      end
`ifdef MULT_FLUSH_EN
      if (issuemult_flush) out_vld <= 1'b0;
`endif
    end
  end

  assign cdb_req = out_vld;
  assign busy    = any_vld | out_vld;

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Bench for mult_issue_ctrl. A behavioural multiplier pipeline feeds mult_p.
// A FIFO scoreboard of issued (tag, product) pairs checks every granted CDB result.
module tb_mult_issue_ctrl;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        issuemult_enable = 1'b0;
  logic [5:0]  issuemult_rdtag = '0;
  logic        issuemult_ready;
  logic        mult_ce;
  logic [31:0] mult_p;
  logic        cdb_req;
  logic        cdb_grant = 1'b0;
  logic [5:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic        busy;
  logic        flush_drv = 1'b0;

  logic [15:0] op_a = '0, op_b = '0;
  logic [31:0] mpipe [LAT];

  always #5 clk = ~clk;

  mult_issue_ctrl #(.LATENCY(LAT), .TAG_W(6), .DATA_W(32)) u_dut (
    .clk              (clk),
    .reset            (reset),
`ifdef MULT_FLUSH_EN
    .issuemult_flush  (flush_drv),
`endif
    .issuemult_enable (issuemult_enable),
    .issuemult_rdtag  (issuemult_rdtag),
    .issuemult_ready  (issuemult_ready),
    .mult_ce          (mult_ce),
    .mult_p           (mult_p),
    .cdb_req          (cdb_req),
    .cdb_grant        (cdb_grant),
    .cdb_tag          (cdb_tag),
    .cdb_data         (cdb_data),
    .busy             (busy)
  );

  // Multiplier model: LAT enabled edges from operands to product.
  always @(posedge clk) begin
    if (mult_ce) begin
      mpipe[0] <= 32'(op_a) * 32'(op_b);
      for (int i = 1; i < LAT; i++) mpipe[i] <= mpipe[i-1];
    end
  end
  assign mult_p = mpipe[LAT-1];

  typedef struct {
    logic [5:0]  tag;
    logic [31:0] p;
  } res_t;

  typedef struct {
    logic [5:0]  tag;
    logic [15:0] a;
    logic [15:0] b;
    logic [31:0] exp_p;
    int          exp_lat;
  } vec_t;

  res_t        sb[$];
  logic [5:0]  popped_tags[$];
  int          pop_steps[$];

  int vectors = 0;
  int miscompares = 0;
  int step_cnt = 0;

  logic        obs_req, obs_ready, obs_ce, obs_busy;
  logic [5:0]  obs_tag;
  logic [31:0] obs_data;
  logic        hold_pend = 1'b0;
  logic [5:0]  hold_tag;
  logic [31:0] hold_data;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (step %0d)", name, act, exp, step_cnt);
    end
  endtask

  // One cycle: drive at negedge, sample 1ns later (the values the next posedge acts on).
  task automatic step(input logic en, input logic [5:0] tg, input logic [15:0] a,
                      input logic [15:0] b, input logic gnt);
    res_t r;
    @(negedge clk);
    issuemult_enable = en;
    issuemult_rdtag  = tg;
    op_a             = a;
    op_b             = b;
    cdb_grant        = gnt;
    #1;
    obs_req   = cdb_req;
    obs_tag   = cdb_tag;
    obs_data  = cdb_data;
    obs_ready = issuemult_ready;
    obs_ce    = mult_ce;
    obs_busy  = busy;
    step_cnt++;
    if (hold_pend)
      chk(obs_req && obs_tag == hold_tag && obs_data == hold_data, "req_hold",
          {31'b0, obs_req, obs_data}, {31'b0, 1'b1, hold_data});
    hold_pend = obs_req && !gnt && !flush_drv;
    hold_tag  = obs_tag;
    hold_data = obs_data;
    if ((!obs_req || gnt) && !flush_drv)
      chk(obs_ready == 1'b1, "ready_free", 64'(obs_ready), 64'd1);
    if (obs_req && gnt) begin
      if (sb.size() == 0) begin
        chk(1'b0, "unexpected_result", {26'b0, obs_tag, obs_data}, 64'd0);
      end else begin
        r = sb.pop_front();
        chk(obs_tag == r.tag && obs_data == r.p, "result",
            {26'b0, obs_tag, obs_data}, {26'b0, r.tag, r.p});
      end
      popped_tags.push_back(obs_tag);
      pop_steps.push_back(step_cnt);
    end
    if (en && obs_ready) begin
      r.tag = tg;
      r.p   = 32'(a) * 32'(b);
      sb.push_back(r);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && sb.size() != 0; i++) step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
    chk(sb.size() == 0, "drain_empty", 64'(sb.size()), 64'd0);
    for (int i = 0; i < 6; i++) step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
    chk(obs_busy == 1'b0, "idle_busy", 64'(obs_busy), 64'd0);
  endtask

  vec_t tbl[4];

  initial begin
    int lat;
    tbl[0] = '{6'h15, 16'd3,     16'd7,     32'd21,         4};
    tbl[1] = '{6'h00, 16'd0,     16'd1234,  32'd0,          4};
    tbl[2] = '{6'h3f, 16'hffff,  16'hffff,  32'hfffe0001,   4};
    tbl[3] = '{6'h2a, 16'd1000,  16'd1000,  32'd1000000,    4};

    // Reset state, sampled mid-reset.
    #3;
    chk(cdb_req == 1'b0 && busy == 1'b0, "rst_req_busy", {cdb_req, busy}, 64'd0);
    chk(mult_ce == 1'b1 && issuemult_ready == 1'b1, "rst_ce_ready", {mult_ce, issuemult_ready}, 64'd3);
    chk(cdb_tag == 6'd0 && cdb_data == 32'd0, "rst_tag_data", {cdb_tag, cdb_data}, 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Table: single issues with the grant held high.
    foreach (tbl[k]) begin
      step(1'b1, tbl[k].tag, tbl[k].a, tbl[k].b, 1'b1);
      chk(obs_ready == 1'b1, "tbl_accept", 64'(obs_ready), 64'd1);
      lat = 0;
      step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
      while (!obs_req && lat < 20) begin
        lat++;
        step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
      end
      chk(lat == tbl[k].exp_lat, "tbl_latency", 64'(lat), 64'(tbl[k].exp_lat));
      chk(obs_tag == tbl[k].tag, "tbl_tag", 64'(obs_tag), 64'(tbl[k].tag));
      chk(obs_data == tbl[k].exp_p, "tbl_data", 64'(obs_data), 64'(tbl[k].exp_p));
      step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
      chk(obs_busy == 1'b0, "tbl_busy_drop", 64'(obs_busy), 64'd0);
    end

    // Back-to-back tags 1..8 with the grant held high: 8 consecutive results in order.
    popped_tags.delete();
    pop_steps.delete();
    for (int t = 1; t <= 8; t++) begin
      step(1'b1, 6'(t), 16'(t + 2), 16'(t * 5), 1'b1);
      chk(obs_ready == 1'b1, "b2b_ready", 64'(obs_ready), 64'd1);
    end
    drain();
    chk(popped_tags.size() == 8, "b2b_count", 64'(popped_tags.size()), 64'd8);
    for (int i = 0; i < popped_tags.size(); i++) begin
      chk(popped_tags[i] == 6'(i + 1), "b2b_order", 64'(popped_tags[i]), 64'(i + 1));
      chk(pop_steps[i] == pop_steps[0] + i, "b2b_consecutive", 64'(pop_steps[i] - pop_steps[0]), 64'(i));
    end

    // Stall: tags 1..3 with no grant for 10 cycles, then release.
    popped_tags.delete();
    for (int t = 1; t <= 3; t++) step(1'b1, 6'(t), 16'(t * 11), 16'(t + 100), 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 6'd0, 16'd0, 16'd0, 1'b0);
    chk(obs_req == 1'b1 && obs_tag == 6'd1, "stall_buffered", {obs_req, obs_tag}, {1'b1, 6'd1});
    chk(obs_data == 32'd11 * 32'd101, "stall_data", 64'(obs_data), 64'(11 * 101));
    chk(obs_ce == 1'b0 && obs_ready == 1'b0, "stall_frozen", {obs_ce, obs_ready}, 64'd0);
    chk(obs_busy == 1'b1, "stall_busy", 64'(obs_busy), 64'd1);
    drain();
    chk(popped_tags.size() == 3, "stall_count", 64'(popped_tags.size()), 64'd3);

    // Grant every other cycle with continuous issue, then fully random.
    for (int i = 0; i < 400; i++) begin
      logic g;
      g = (i < 200) ? 1'(i % 2) : 1'($urandom_range(0, 1));
      step(i < 200 ? 1'b1 : 1'($urandom_range(0, 3) != 0), 6'($urandom), 16'($urandom),
           16'($urandom), g);
    end
    drain();

    // Asynchronous reset with 3 in flight and 1 buffered.
    for (int t = 10; t <= 13; t++) step(1'b1, 6'(t), 16'(t), 16'(t), 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 16'd0, 16'd0, 1'b0);
    chk(obs_req == 1'b1 && obs_ce == 1'b0, "pre_reset_full", {obs_req, obs_ce}, 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk(cdb_req == 1'b0 && busy == 1'b0, "async_reset_clear", {cdb_req, busy}, 64'd0);
    chk(issuemult_ready == 1'b1, "async_reset_ready", 64'(issuemult_ready), 64'd1);
    sb.delete();
    hold_pend = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    popped_tags.delete();
    step(1'b1, 6'h2a, 16'd5, 16'd6, 1'b1);
    drain();
    chk(popped_tags.size() == 1, "post_reset_count", 64'(popped_tags.size()), 64'd1);
    if (popped_tags.size() > 0)
      chk(popped_tags[0] == 6'h2a, "post_reset_tag", 64'(popped_tags[0]), 64'h2a);

`ifdef MULT_FLUSH_EN
    // Flush with 2 in flight and 1 buffered, with an issue presented the same cycle.
    for (int t = 20; t <= 22; t++) step(1'b1, 6'(t), 16'(t), 16'd3, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 6'd0, 16'd0, 16'd0, 1'b0);
    flush_drv = 1'b1;
    step(1'b1, 6'h33, 16'd9, 16'd9, 1'b0);
    chk(obs_ready == 1'b0, "flush_ready", 64'(obs_ready), 64'd0);
    flush_drv = 1'b0;
    sb.delete();
    popped_tags.delete();
    step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
    chk(obs_req == 1'b0, "flush_req_drop", 64'(obs_req), 64'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 6'd0, 16'd0, 16'd0, 1'b1);
    chk(popped_tags.size() == 0, "flush_nothing", 64'(popped_tags.size()), 64'd0);
    step(1'b1, 6'h07, 16'd12, 16'd12, 1'b1);
    drain();
    chk(popped_tags.size() == 1, "flush_next_issue", 64'(popped_tags.size()), 64'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
